// File: rtl/pix_out_framer_if.sv
// Output pixel stream of the framer: 4 pixels x 3 components x 14 bits per
// beat with frame/line markers, using a valid/ready handshake.
//   pix_out_data  : clamped pixels; component c of pixel p at [(p*3+c)*14 +: 14]
//   pix_out_valid : beat valid
//   pix_out_ready : downstream accept
//   pix_out_sof   : first beat of frame
//   pix_out_sol   : first beat of line
//   pix_out_eol   : last beat of line
//   pix_out_eof   : last beat of frame
// The master modport is the framer; the slave modport is the consumer.
interface pix_out_framer_if;
  logic [167:0] pix_out_data;
  logic         pix_out_valid;
  logic         pix_out_ready;
  logic         pix_out_sof;
  logic         pix_out_sol;
  logic         pix_out_eol;
  logic         pix_out_eof;

  modport master (
    output pix_out_data, pix_out_valid, pix_out_sof, pix_out_sol,
           pix_out_eol, pix_out_eof,
    input  pix_out_ready
  );

  modport slave (
    input  pix_out_data, pix_out_valid, pix_out_sof, pix_out_sol,
           pix_out_eol, pix_out_eof,
    output pix_out_ready
  );
endinterface

// File: rtl/pix_out_framer.sv
// Pixel output framer. Takes the merged 4-pixel-per-cycle stream from the
// slice mux, clamps every component to the configured bit depth, tags each
// beat with sof/sol/eol/eof from its own beat/line counters and queues the
// result in a first-word-fall-through FIFO behind a valid/ready interface.
//   clk_out_int        : pixel output clock
//   rst_n              : asynchronous active-low reset
//   flush              : synchronous clear of FIFO, counters and frame_err
//   frame_width        : pixels per line (multiple of 4, >= 8)
//   frame_height       : lines per frame (>= 1)
//   bits_per_component : output bit depth, 8..14
//   pixs_in            : input pixels, same packing as pix_out_data
//   pixs_in_valid      : input beat qualifier (no ready; mux obeys hold)
//   pixs_in_eof        : eof level from the mux
//   hold_upstream      : backpressure to the mux read side
//   frame_err          : sticky overflow / premature-eof flag
//   pix_out            : output stream (master side of pix_out_framer_if)
module pix_out_framer #(
  parameter int FIFO_DEPTH = 16,
  parameter int AF_MARGIN  = 4
) (
  input  logic                   clk_out_int,
  input  logic                   rst_n,
  input  logic                   flush,
  input  logic [15:0]            frame_width,
  input  logic [15:0]            frame_height,
  input  logic [3:0]             bits_per_component,
  input  logic [167:0]           pixs_in,
  input  logic                   pixs_in_valid,
  input  logic                   pixs_in_eof,
  output logic                   hold_upstream,
  output logic                   frame_err,
  pix_out_framer_if.master       pix_out
);

  localparam int DATA_W  = 14;
  localparam int PIX_N   = 4;
  localparam int COMP_N  = 3;
  localparam int PIX_W   = PIX_N * COMP_N * DATA_W;
  localparam int ENTRY_W = PIX_W + 4;
  localparam int AW      = $clog2(FIFO_DEPTH);
  localparam int CNT_W   = AW + 1;
  localparam logic [CNT_W-1:0] HOLD_LVL = CNT_W'(FIFO_DEPTH - AF_MARGIN);
  localparam logic [CNT_W-1:0] FULL_LVL = CNT_W'(FIFO_DEPTH);

  // Saturate to 2^bpc-1; the result never has bits set above bpc.
  function automatic logic [DATA_W-1:0] clamp_comp(input logic [DATA_W-1:0] v,
                                                   input logic [3:0] bpc);
    logic [DATA_W:0]   lim_w;
    logic [DATA_W-1:0] lim;
    lim_w = ({{DATA_W{1'b0}}, 1'b1} << bpc) - {{DATA_W{1'b0}}, 1'b1};
    lim   = (bpc >= 4'd14) ? {DATA_W{1'b1}} : lim_w[DATA_W-1:0];
    return (v > lim) ? lim : v;
  endfunction

  logic [13:0]        beats_per_line;
  logic [13:0]        beat_cnt;
  logic [15:0]        line_cnt;
  logic               last_beat;
  logic               last_line;
  logic               eof_q;
  logic               resync;
  logic [PIX_W-1:0]   clamped;

  logic [ENTRY_W-1:0] entry_p1;
  logic               vld_p1;

  logic [ENTRY_W-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]      wr_ptr;
  logic [AW-1:0]      rd_ptr;
  logic [CNT_W-1:0]   count;
  logic [CNT_W-1:0]   count_next;
  logic               empty;
  logic               full;
  logic               pop;
  logic               push_ok;
  logic               drop;
  logic [ENTRY_W-1:0] head;

  assign beats_per_line = 14'(frame_width >> 2);
  assign last_beat      = (beat_cnt == beats_per_line - 14'd1);
  assign last_line      = (line_cnt == frame_height - 16'd1);
  // A rising eof while mid-frame means the mux lost beats: resync to frame start.
  assign resync         = pixs_in_eof & ~eof_q & ((beat_cnt != 14'd0) | (line_cnt != 16'd0));

  always_comb begin
    clamped = '0;
    for (int i = 0; i < PIX_N * COMP_N; i++)
      clamped[i*DATA_W +: DATA_W] = clamp_comp(pixs_in[i*DATA_W +: DATA_W], bits_per_component);
  end

  always_ff @(posedge clk_out_int or negedge rst_n) begin
    if (!rst_n) begin
      beat_cnt <= '0;
      line_cnt <= '0;
      eof_q    <= 1'b0;
      vld_p1   <= 1'b0;
    end else begin
      eof_q <= pixs_in_eof;
      if (flush) begin
        beat_cnt <= '0;
        line_cnt <= '0;
        vld_p1   <= 1'b0;
      end else begin
        vld_p1 <= pixs_in_valid;
        if (resync) begin
          beat_cnt <= '0;
          line_cnt <= '0;
        end else if (pixs_in_valid) begin
          if (last_beat) begin
            beat_cnt <= '0;
            line_cnt <= last_line ? 16'd0 : line_cnt + 16'd1;
          end else begin
            beat_cnt <= beat_cnt + 14'd1;
          end
        end
      end
    end
  end

  // ---- stage 1: clamped pixels + markers, taken from pre-update counters ----
  always_ff @(posedge clk_out_int) begin
    if (pixs_in_valid)
      entry_p1 <= {(beat_cnt == 14'd0) & (line_cnt == 16'd0),
                   (beat_cnt == 14'd0),
                   last_beat,
                   last_beat & last_line,
                   clamped};
  end

  // ---- stage 2: FIFO write; read side is first-word-fall-through ----
  assign empty      = (count == '0);
  assign full       = (count == FULL_LVL);
  assign pop        = ~empty & pix_out.pix_out_ready;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign push_ok    = vld_p1 & (~full | pop);
  assign drop       = vld_p1 & full & ~pop;
  assign count_next = count + CNT_W'(push_ok) - CNT_W'(pop);

  always_ff @(posedge clk_out_int or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      count         <= '0;
      hold_upstream <= 1'b0;
      frame_err     <= 1'b0;
    end else if (flush) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      count         <= '0;
      hold_upstream <= 1'b0;
      frame_err     <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop)     rd_ptr <= rd_ptr + AW'(1);
      count         <= count_next;
      hold_upstream <= (count_next >= HOLD_LVL);
      frame_err     <= frame_err | drop | resync;
    end
  end

  always_ff @(posedge clk_out_int) begin
    if (push_ok && !flush)
      mem[wr_ptr] <= entry_p1;
  end

  // Outputs are forced to zero while empty so nothing stale leaks out.
  assign head                  = mem[rd_ptr];
  assign pix_out.pix_out_valid = ~empty;
  assign pix_out.pix_out_data  = empty ? '0 : head[PIX_W-1:0];
  assign pix_out.pix_out_sof   = ~empty & head[PIX_W+3];
  assign pix_out.pix_out_sol   = ~empty & head[PIX_W+2];
  assign pix_out.pix_out_eol   = ~empty & head[PIX_W+1];
  assign pix_out.pix_out_eof   = ~empty & head[PIX_W];

endmodule

// File: tb/tb_pix_out_framer.sv
// Self-checking bench for pix_out_framer: a queue-based frame model plus
// directed scenarios with literal expectations.
module tb_pix_out_framer;

  typedef struct packed {
    logic [167:0] d;
    logic         sof;
    logic         sol;
    logic         eol;
    logic         eof;
  } beat_t;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         flush;
  logic [15:0]  fw;
  logic [15:0]  fh;
  logic [3:0]   bpc;
  logic [167:0] din;
  logic         din_v;
  logic         din_eof;
  logic         hold;
  logic         ferr;

  int total = 0;
  int bad   = 0;

  pix_out_framer_if out_if();

  pix_out_framer #(.FIFO_DEPTH(16), .AF_MARGIN(4)) dut (
    .clk_out_int       (clk),
    .rst_n             (rst_n),
    .flush             (flush),
    .frame_width       (fw),
    .frame_height      (fh),
    .bits_per_component(bpc),
    .pixs_in           (din),
    .pixs_in_valid     (din_v),
    .pixs_in_eof       (din_eof),
    .hold_upstream     (hold),
    .frame_err         (ferr),
    .pix_out           (out_if)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [171:0] act, input logic [171:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  function automatic logic [167:0] gen(input int n);
    logic [167:0] v;
    for (int i = 0; i < 12; i++) v[i*14 +: 14] = 14'((n * 12 + i) * 97 + 5);
    return v;
  endfunction

  // Model beat: clamp via min(), markers from the flat beat index in the frame.
  function automatic beat_t mk(input logic [167:0] d, input int k, input int w,
                               input int h, input int b);
    beat_t r;
    int bpl, lim, v;
    bpl = w / 4;
    lim = (1 << b) - 1;
    for (int i = 0; i < 12; i++) begin
      v = int'(d[i*14 +: 14]);
      r.d[i*14 +: 14] = 14'((v > lim) ? lim : v);
    end
    r.sof = (k == 0);
    r.sol = (k % bpl == 0);
    r.eol = (k % bpl == bpl - 1);
    r.eof = (k == bpl * h - 1);
    return r;
  endfunction

  // ---------------- behavioural model ----------------
  beat_t q[$];
  beat_t st;
  bit    st_v, m_err, m_hold, eof_prev, pop_m, full_m;
  int    k, kb;

  always @(posedge clk) begin
    if (!rst_n) begin
      q.delete(); st_v = 0; k = 0; m_err = 0; m_hold = 0; eof_prev = 0;
    end else begin
      if (flush) begin
        q.delete(); st_v = 0; k = 0; m_err = 0; m_hold = 0;
      end else begin
        pop_m  = (q.size() > 0) && out_if.pix_out_ready;
        full_m = (q.size() == 16);
        if (pop_m) void'(q.pop_front());
        if (st_v) begin
          if (!full_m || pop_m) q.push_back(st);
          else m_err = 1;
        end
        m_hold = (q.size() >= 12);
        kb   = k;
        st_v = din_v;
        if (din_v) begin
          st = mk(din, k, int'(fw), int'(fh), int'(bpc));
          k  = (k + 1) % ((int'(fw) / 4) * int'(fh));
        end
        if (din_eof && !eof_prev && kb != 0) begin
          m_err = 1;
          k = 0;
        end
      end
      eof_prev = din_eof;
    end
  end

  // ---------------- per-cycle compare + output log ----------------
  beat_t logq[$];

  always @(negedge clk) begin
    if (rst_n) begin
      chk("valid", 172'(out_if.pix_out_valid), 172'(q.size() > 0));
      if (q.size() > 0)
        chk("head", {out_if.pix_out_data, out_if.pix_out_sof, out_if.pix_out_sol,
                     out_if.pix_out_eol, out_if.pix_out_eof}, q[0]);
      chk("hold", 172'(hold), 172'(m_hold));
      chk("ferr", 172'(ferr), 172'(m_err));
      if (out_if.pix_out_valid && out_if.pix_out_ready)
        logq.push_back({out_if.pix_out_data, out_if.pix_out_sof, out_if.pix_out_sol,
                        out_if.pix_out_eol, out_if.pix_out_eof});
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic drive(input logic v, input logic [167:0] d);
    @(posedge clk); #1;
    din_v = v;
    din   = d;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, '0);
  endtask

  task automatic do_flush();
    @(posedge clk); #1;
    flush = 1'b1; din_v = 1'b0;
    @(posedge clk); #1;
    flush = 1'b0;
    logq.delete();
  endtask

  int    sent, hold_at, stall;
  bit    stable, snap_ok;
  logic [167:0] snap;

  initial begin
    rst_n = 1'b0; flush = 1'b0; fw = 16'd16; fh = 16'd2; bpc = 4'd14;
    din = '0; din_v = 1'b0; din_eof = 1'b0; out_if.pix_out_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", 172'(out_if.pix_out_valid), 172'(0));
    chk("rst_data",  172'(out_if.pix_out_data), 172'(0));
    chk("rst_marks", 172'({out_if.pix_out_sof, out_if.pix_out_sol,
                           out_if.pix_out_eol, out_if.pix_out_eof}), 172'(0));
    chk("rst_hold",  172'(hold), 172'(0));
    chk("rst_ferr",  172'(ferr), 172'(0));
    @(posedge clk); #1;
    rst_n = 1'b1;

    // 1: 16x2 frame, continuous input, ready high
    out_if.pix_out_ready = 1'b1;
    do_flush();
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, gen(i));
      @(negedge clk);
      if (i == 1) chk("lat_early", 172'(out_if.pix_out_valid), 172'(0));
      if (i == 2) chk("lat_on",    172'(out_if.pix_out_valid), 172'(1));
    end
    idle(5);
    chk("t1_n",     172'(logq.size()), 172'(8));
    chk("t1_b0",    172'({logq[0].sof, logq[0].sol, logq[0].eol}), 172'(3'b110));
    chk("t1_b3",    172'({logq[3].eol, logq[3].eof}), 172'(2'b10));
    chk("t1_b4",    172'({logq[4].sof, logq[4].sol}), 172'(2'b01));
    chk("t1_b7",    172'({logq[7].eol, logq[7].eof}), 172'(2'b11));
    chk("t1_data5", 172'(logq[5].d), 172'(gen(5)));

    // 2: clamp at 10 bits
    bpc = 4'd10;
    do_flush();
    drive(1'b1, {12{14'h3FFF}});
    drive(1'b1, {12{14'h0155}});
    drive(1'b1, {12{14'h0400}});
    drive(1'b1, {12{14'h03FF}});
    idle(5);
    chk("t2_n",   172'(logq.size()), 172'(4));
    chk("t2_sat", 172'(logq[0].d), 172'({12{14'h03FF}}));
    chk("t2_pass",172'(logq[1].d), 172'({12{14'h0155}}));
    chk("t2_400", 172'(logq[2].d), 172'({12{14'h03FF}}));
    chk("t2_3ff", 172'(logq[3].d), 172'({12{14'h03FF}}));

    // 3: stalled output, upstream honours hold_upstream
    bpc = 4'd14; fh = 16'd8;
    out_if.pix_out_ready = 1'b0;
    do_flush();
    sent = 0; hold_at = -1; stall = 0; stable = 1; snap_ok = 0;
    for (int cyc = 0; cyc < 300 && logq.size() < 20; cyc++) begin
      @(posedge clk); #1;
      if (hold_at < 0 && hold) hold_at = sent;
      if (sent < 20 && !hold) begin
        din_v = 1'b1; din = gen(sent); sent++;
      end else begin
        din_v = 1'b0;
      end
      if (hold_at >= 0 && stall < 6) begin
        stall++;
        if (stall == 6) out_if.pix_out_ready = 1'b1;
      end
      @(negedge clk);
      if (!out_if.pix_out_ready && out_if.pix_out_valid) begin
        if (!snap_ok) begin snap = out_if.pix_out_data; snap_ok = 1; end
        else if (out_if.pix_out_data !== snap) stable = 0;
      end
    end
    idle(2);
    chk("t3_hold_at", 172'(hold_at), 172'(13));
    chk("t3_n",       172'(logq.size()), 172'(20));
    for (int i = 0; i < 20 && i < logq.size(); i++)
      chk($sformatf("t3_order%0d", i), 172'(logq[i].d), 172'(gen(i)));
    chk("t3_stable",  172'(stable), 172'(1));
    chk("t3_ferr",    172'(ferr), 172'(0));

    // 4: overflow by ignoring hold_upstream
    out_if.pix_out_ready = 1'b0;
    do_flush();
    for (int i = 0; i < 17; i++) drive(1'b1, gen(100 + i));
    idle(3);
    @(negedge clk);
    chk("t4_ferr", 172'(ferr), 172'(1));
    @(posedge clk); #1;
    out_if.pix_out_ready = 1'b1;
    idle(25);
    chk("t4_n",     172'(logq.size()), 172'(16));
    chk("t4_first", 172'(logq[0].d), 172'(gen(100)));
    chk("t4_last",  172'(logq[15].d), 172'(gen(115)));

    // 5: premature eof after 5 beats of a 16x2 frame
    fh = 16'd2;
    do_flush();
    for (int i = 0; i < 5; i++) drive(1'b1, gen(200 + i));
    @(posedge clk); #1;
    din_v = 1'b0; din_eof = 1'b1;
    @(posedge clk); #1;
    din_eof = 1'b0;
    drive(1'b1, gen(205));
    idle(5);
    chk("t5_ferr", 172'(ferr), 172'(1));
    chk("t5_n",    172'(logq.size()), 172'(6));
    chk("t5_b4",   172'({logq[4].sof, logq[4].sol}), 172'(2'b01));
    chk("t5_b5",   172'({logq[5].sof, logq[5].sol}), 172'(2'b11));

    // 6: flush with beats queued and frame_err set
    out_if.pix_out_ready = 1'b0;
    do_flush();
    for (int i = 0; i < 6; i++) drive(1'b1, gen(300 + i));
    @(posedge clk); #1;
    din_v = 1'b0; din_eof = 1'b1;
    @(posedge clk); #1;
    din_eof = 1'b0;
    idle(2);
    @(negedge clk);
    chk("t6_pre_valid", 172'(out_if.pix_out_valid), 172'(1));
    chk("t6_pre_ferr",  172'(ferr), 172'(1));
    @(posedge clk); #1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    @(negedge clk);
    chk("t6_valid", 172'(out_if.pix_out_valid), 172'(0));
    chk("t6_hold",  172'(hold), 172'(0));
    chk("t6_ferr",  172'(ferr), 172'(0));
    logq.delete();
    @(posedge clk); #1;
    out_if.pix_out_ready = 1'b1;
    drive(1'b1, gen(400));
    idle(5);
    chk("t6_n",   172'(logq.size()), 172'(1));
    chk("t6_sof", 172'(logq[0].sof), 172'(1));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pix_out_framer.md
Name: pix_out_framer

Overview:
- Downstream consumer of the slice multiplexer, in the clk_out_int domain.
- Accepts the merged 4-pixel-per-cycle stream: 4 pixels x 3 components x 14 bits, with valid and eof-level.
- Clamps each component to the configured bit depth and attaches frame and line markers (sof/sol/eol/eof) from its own counters.
- Buffers beats in a small FIFO behind a valid/ready output interface, and gives the mux a backpressure level.

Parameters:
- FIFO_DEPTH, 16: output FIFO entries; power of 2, at least 8.
- AF_MARGIN, 4: free entries still left when hold_upstream asserts; covers the mux read-to-valid latency.

Ports:
- clk_out_int  in  1  pixel output clock.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  synchronous clear of FIFO, counters and error flag.
- frame_width  in  16  pixels per frame line; must be a multiple of 4 and at least 8.
- frame_height  in  16  lines per frame; at least 1.
- bits_per_component  in  4  valid range 8..14.
- pixs_in  in  168  4 pixels; component c of pixel p is at bits [(p*3+c)*14 +: 14].
- pixs_in_valid  in  1  input beat qualifier; no input ready.
- pixs_in_eof  in  1  eof level from the mux.
- hold_upstream  out  1  backpressure to the mux read side.
- pix_out_data  out  168  clamped pixels, same packing as pixs_in.
- pix_out_valid  out  1  output beat valid.
- pix_out_ready  in  1  downstream accept.
- pix_out_sof  out  1  first beat of frame.
- pix_out_sol  out  1  first beat of line.
- pix_out_eol  out  1  last beat of line.
- pix_out_eof  out  1  last beat of frame.
- frame_err  out  1  sticky error flag.

Behaviour:
- Reset is asynchronous, active-low, clock clk_out_int. All outputs reset to 0, the FIFO is empty and all counters are 0.
- beats_per_line = frame_width>>2, held in 14 bits.
- beat_cnt (14 bits) and line_cnt (16 bits) advance on each pixs_in_valid.
  - When beat_cnt reaches beats_per_line-1, it wraps to 0 and line_cnt increments.
  - When line_cnt reaches frame_height-1 and the line completes, both counters wrap to 0.
- Stage 1 (registered) computes, per component, out = min(in, 2^bpc-1) and zeroes bits above bpc. It also computes the markers for the beat:
  - sof: beat_cnt==0 and line_cnt==0.
  - sol: beat_cnt==0.
  - eol: beat_cnt==beats_per_line-1.
  - eof: eol and line_cnt==frame_height-1.
- The stage-1 output is written to the FIFO as 172 bits: data plus 4 markers. The write is unconditional; the mux is trusted to obey hold_upstream.
- FIFO overflow: if a write happens while the FIFO is full, drop the beat and set frame_err.
- FIFO read side is first-word-fall-through.
  - pix_out_valid = ~empty.
  - Data and markers come from the head entry and stay stable while valid and not ready.
  - Pop on valid & ready.
- Latency: an input beat appears on the outputs 2 clk_out_int cycles later when the FIFO is empty. Throughput is 1 beat per cycle.
- hold_upstream is registered and equals (count >= FIFO_DEPTH-AF_MARGIN), where count is the occupancy after the current cycle's push/pop.
- Simultaneous push and pop on a full FIFO is legal and leaves count unchanged.
- A rising edge of pixs_in_eof while the counters are not both 0 is a premature eof:
  - Set frame_err.
  - Force both counters to 0 (resync).
  - FIFO contents are untouched.
- Input valid arriving in the same cycle as the eof rising edge: the beat uses the counters before the resync.
- flush:
  - Empties the FIFO, clears counters, frame_err and hold_upstream.
  - The in-flight stage-1 beat is discarded.
  - Takes priority over any input in the same cycle.
- frame_err is cleared only by reset or flush.
- Config inputs are static while frames are active. A change mid-frame gives undefined marker placement but must not corrupt FIFO pointers.

Test Plan:
- frame_width=16, frame_height=2, bpc=14, pixs_in_valid held high, ready=1 -> 8 output beats at 2-cycle latency.
  - Beat 0: sof=1, sol=1.
  - Beats 3 and 7: eol=1.
  - Beat 4: sol=1.
  - Beat 7: eof=1.
  - Data equals the input.
- bpc=10, all input components 14'h3FFF, then 14'h0155 -> output components 14'h03FF, then 14'h0155.
- ready=0, stream 20 beats while honoring hold_upstream -> hold_upstream rises once count reaches 12.
  - Then release ready: all beats emerge in order, no frame_err, data stable while stalled.
- Ignore hold_upstream and push 17 beats with ready=0 -> frame_err=1 and exactly 16 beats drain.
- frame_width=16, frame_height=2: pulse pixs_in_eof high after 5 beats.
  - Required: frame_err=1, and the next beat carries sof=1.
- Mid-stream flush with 6 beats queued -> next cycle pix_out_valid=0, hold_upstream=0, frame_err=0; the next beat carries sof=1.
